// File: rtl/simon_ctrl_pkg.sv
// Shared parameters and controller state encoding for the SIMON request arbiter.
package simon_ctrl_pkg;

    localparam int N = 64;
    localparam int M = 2;

    typedef enum logic [2:0] {
        IDLE,
        KEY_REQ,
        KEY_WAIT,
        DATA_REQ,
        DATA_WAIT,
        READ
    } state_t;

endpackage

// File: rtl/simon_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that was not served last wins.
module simon_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (&elig): grant = last ? 2'b01 : 2'b10;
            default: grant = elig;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/simon_req_arbiter.sv
// Schedules encrypt/decrypt jobs from two clients onto one SIMON_128128 core,
// skipping the key schedule when the loaded key already matches.
module simon_req_arbiter
    import simon_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      nR,
    input  logic [1:0]                rq_valid,
    output logic [1:0]                rq_ready,
    input  logic [1:0]                rq_enc_dec,
    input  logic [1:0][2*N-1:0]       rq_block,
    input  logic [1:0][M-1:0][N-1:0]  rq_key,
    output logic [1:0]                rs_valid,
    input  logic [1:0]                rs_ready,
    output logic [1:0][2*N-1:0]       rs_block,
    output logic                      co_newKey,
    output logic                      co_newData,
    output logic                      co_readData,
    output logic                      co_enc_dec,
    output logic [M-1:0][N-1:0]       co_key,
    output logic [2*N-1:0]            co_plain,
    input  logic                      co_ldKey,
    input  logic                      co_doneKey,
    input  logic                      co_ldData,
    input  logic                      co_doneData,
    input  logic [2*N-1:0]            co_cipher
);

    state_t               state;
    state_t               state_nx;
    logic [2*N-1:0]       job_block;
    logic [M-1:0][N-1:0]  job_key;
    logic [M-1:0][N-1:0]  loaded_key;
    logic                 job_enc_dec;
    logic                 job_id;
    logic                 key_valid;
    logic [1:0]           elig;
    logic [1:0]           grant;
    logic                 accept;
    logic                 gid;
    logic                 key_hit;

    assign elig     = rq_valid & ~rs_valid & {2{state == IDLE && nR}};
    assign accept   = |grant;
    assign gid      = grant[1];
    assign rq_ready = grant;
    assign key_hit  = key_valid && (rq_key[gid] == loaded_key);

    assign co_plain   = job_block;
    assign co_enc_dec = job_enc_dec;

    simon_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (nR),
        .elig   (elig),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_nx    = state;
        co_newKey   = 1'b0;
        co_newData  = 1'b0;
        co_readData = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = key_hit ? DATA_REQ : KEY_REQ;
            end
            KEY_REQ: begin
                co_newKey = 1'b1;
                if (co_ldKey) state_nx = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (co_doneKey) state_nx = DATA_REQ;
            end
            DATA_REQ: begin
                co_newData = 1'b1;
                if (co_ldData) state_nx = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (co_doneData) state_nx = READ;
            end
            READ: begin
                co_readData = 1'b1;
                if (!co_doneData) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state       <= IDLE;
            job_block   <= '0;
            job_key     <= '0;
            job_enc_dec <= 1'b0;
            job_id      <= 1'b0;
            loaded_key  <= '0;
            key_valid   <= 1'b0;
            co_key      <= '0;
            rs_valid    <= '0;
            rs_block    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                job_block   <= rq_block[gid];
                job_key     <= rq_key[gid];
                job_enc_dec <= rq_enc_dec[gid];
                job_id      <= gid;
                if (!key_hit) co_key <= rq_key[gid];
            end
            if (state == KEY_REQ && co_ldKey) begin
                loaded_key <= job_key;
                key_valid  <= 1'b1;
            end
            // A slot cannot complete and drain in the same cycle: it is ineligible while full.
            for (int r = 0; r < 2; r++) begin
                if (state == DATA_WAIT && co_doneData && int'(job_id) == r) begin
                    rs_valid[r] <= 1'b1;
                    rs_block[r] <= co_cipher;
                end else if (rs_ready[r]) begin
                    rs_valid[r] <= 1'b0;
                end
            end
        end
    end

endmodule
